// File: rtl/maze_path_writer.sv
// Cursor/path writer for the maze VGA renderer: synchronizes four buttons,
// walks a cursor over a grid of up to GRID_MAX x GRID_MAX cells and marks visited cells.
module maze_path_writer #(
    parameter int GRID_MAX = 3,
    parameter int IDX_W    = 2,
    parameter int CNT_W    = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           btn_up,
    input  logic                           btn_down,
    input  logic                           btn_left,
    input  logic                           btn_right,
    input  logic [2:0]                     width_in,
    input  logic [2:0]                     height_in,
    output logic [GRID_MAX*GRID_MAX-1:0]   path_data,
    output logic [2:0]                     maze_width,
    output logic [2:0]                     maze_height,
    output logic [IDX_W-1:0]               cur_x,
    output logic [IDX_W-1:0]               cur_y,
    output logic                           busy,
    output logic                           done,
    output logic                           err,
    output logic                           blocked,
    output logic [CNT_W-1:0]               move_count
);
    localparam int NC = GRID_MAX * GRID_MAX;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t state_q, state_d;

    logic [3:0]       s1_q, s2_q, prev_q, edg;
    logic [NC-1:0]    path_q, path_d;
    logic [2:0]       wid_q, wid_d, hgt_q, hgt_d;
    logic [IDX_W-1:0] x_q, x_d, y_q, y_d;
    logic             err_q, err_d, blk_q, blk_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       dims_ok, one_cell, mv_any, mv_in, corner, run_mv;
    logic [2:0] nx, ny;
    logic [3:0] pidx;

    // Bit order {up, down, left, right} doubles as the priority order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_q   <= '0;
            s2_q   <= '0;
            prev_q <= '0;
        end else begin
            s1_q   <= {btn_up, btn_down, btn_left, btn_right};
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end
    assign edg = s2_q & ~prev_q;

    assign dims_ok  = (width_in != 3'd0) && (width_in <= 3'(GRID_MAX)) &&
                      (height_in != 3'd0) && (height_in <= 3'(GRID_MAX));
    assign one_cell = (width_in == 3'd1) && (height_in == 3'd1);

    always_comb begin
        nx     = 3'(x_q);
        ny     = 3'(y_q);
        mv_any = |edg;
        mv_in  = 1'b0;
        if (edg[3]) begin
            mv_in = (y_q != '0);
            ny    = ny - 3'd1;
        end else if (edg[2]) begin
            mv_in = (ny + 3'd1) < hgt_q;
            ny    = ny + 3'd1;
        end else if (edg[1]) begin
            mv_in = (x_q != '0);
            nx    = nx - 3'd1;
        end else if (edg[0]) begin
            mv_in = (nx + 3'd1) < wid_q;
            nx    = nx + 3'd1;
        end
        corner = (nx == wid_q - 3'd1) && (ny == hgt_q - 3'd1);
        pidx   = 4'(nx) * 4'(GRID_MAX) + 4'(ny);
        run_mv = (state_q == RUN) && !start && mv_any;
    end

    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (start)
            state_d = !dims_ok ? IDLE : (one_cell ? FIN : RUN);
        else if (run_mv && mv_in && corner)
            state_d = FIN;
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == FIN);
    end

    always_comb begin
        path_d = path_q;
        wid_d  = wid_q;
        hgt_d  = hgt_q;
        x_d    = x_q;
        y_d    = y_q;
        err_d  = err_q;
        blk_d  = 1'b0;
        cnt_d  = cnt_q;
        if (start) begin
            if (dims_ok) begin
                wid_d  = width_in;
                hgt_d  = height_in;
                err_d  = 1'b0;
                path_d = NC'(1);
                x_d    = '0;
                y_d    = '0;
                cnt_d  = '0;
            end else begin
                err_d  = 1'b1;
            end
        end else if (run_mv) begin
            if (mv_in) begin
                x_d    = nx[IDX_W-1:0];
                y_d    = ny[IDX_W-1:0];
                path_d = path_q | (NC'(1) << pidx);
                if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            end else begin
                blk_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            path_q <= '0;
            wid_q  <= '0;
            hgt_q  <= '0;
            x_q    <= '0;
            y_q    <= '0;
            err_q  <= 1'b0;
            blk_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            path_q <= path_d;
            wid_q  <= wid_d;
            hgt_q  <= hgt_d;
            x_q    <= x_d;
            y_q    <= y_d;
            err_q  <= err_d;
            blk_q  <= blk_d;
            cnt_q  <= cnt_d;
        end
    end

    assign path_data   = path_q;
    assign maze_width  = wid_q;
    assign maze_height = hgt_q;
    assign cur_x       = x_q;
    assign cur_y       = y_q;
    assign err         = err_q;
    assign blocked     = blk_q;
    assign move_count  = cnt_q;
endmodule

// File: tb/tb_maze_path_writer.sv
// Bench for maze_path_writer: directed scenarios plus a random walk, all
// checked every cycle against a cell-level model of the maze game.
module tb_maze_path_writer;
    logic       clk = 1'b0;
    logic       reset, start;
    logic [3:0] btn;   // {up, down, left, right}
    logic [2:0] width_in, height_in;
    logic [8:0] path_data;
    logic [2:0] maze_width, maze_height;
    logic [1:0] cur_x, cur_y;
    logic       busy, done, err, blocked;
    logic [7:0] move_count;

    int n_cmp = 0, n_bad = 0, blk_seen = 0;

    // model: game state in plain integers, button history per cycle
    int         m_st;  // 0 idle, 1 running, 2 finished
    int         m_w, m_h, m_x, m_y, m_cnt;
    logic [8:0] m_path;
    logic       m_err, m_blk;
    logic [3:0] h1, h2, h3;

    maze_path_writer dut (
        .clk(clk), .reset(reset), .start(start),
        .btn_up(btn[3]), .btn_down(btn[2]), .btn_left(btn[1]), .btn_right(btn[0]),
        .width_in(width_in), .height_in(height_in),
        .path_data(path_data), .maze_width(maze_width), .maze_height(maze_height),
        .cur_x(cur_x), .cur_y(cur_y), .busy(busy), .done(done), .err(err),
        .blocked(blocked), .move_count(move_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model();
        logic [3:0] e;
        int dx, dy, nx, ny;
        if (!reset) begin
            m_st = 0; m_w = 0; m_h = 0; m_x = 0; m_y = 0; m_cnt = 0;
            m_path = '0; m_err = 0; m_blk = 0;
            h1 = '0; h2 = '0; h3 = '0;
            return;
        end
        // a press seen at edge n-2 but not n-3 acts at edge n
        e = h2 & ~h3;
        h3 = h2; h2 = h1; h1 = btn;
        m_blk = 0;
        if (start) begin
            if (width_in >= 1 && width_in <= 3 && height_in >= 1 && height_in <= 3) begin
                m_w = width_in; m_h = height_in; m_err = 0;
                m_path = 9'd1; m_x = 0; m_y = 0; m_cnt = 0;
                m_st = (m_w == 1 && m_h == 1) ? 2 : 1;
            end else begin
                m_err = 1; m_st = 0;
            end
        end else if (m_st == 1 && e != 0) begin
            dx = 0; dy = 0;
            if (e[3])      dy = -1;
            else if (e[2]) dy = 1;
            else if (e[1]) dx = -1;
            else           dx = 1;
            nx = m_x + dx; ny = m_y + dy;
            if (nx >= 0 && nx < m_w && ny >= 0 && ny < m_h) begin
                m_x = nx; m_y = ny;
                m_path[3*nx+ny] = 1'b1;
                if (m_cnt < 255) m_cnt++;
                if (nx == m_w - 1 && ny == m_h - 1) m_st = 2;
            end else begin
                m_blk = 1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model();
        #1;
        chk("path", 32'(path_data), 32'(m_path));
        chk("width", 32'(maze_width), 32'(m_w));
        chk("height", 32'(maze_height), 32'(m_h));
        chk("cur_x", 32'(cur_x), 32'(m_x));
        chk("cur_y", 32'(cur_y), 32'(m_y));
        chk("busy", 32'(busy), 32'(m_st == 1));
        chk("done", 32'(done), 32'(m_st == 2));
        chk("err", 32'(err), 32'(m_err));
        chk("blocked", 32'(blocked), 32'(m_blk));
        chk("count", 32'(move_count), 32'(m_cnt));
        if (blocked) blk_seen++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0; repeat (2) step(); reset = 1'b1;
    endtask

    task automatic go(input logic [2:0] w, input logic [2:0] h);
        width_in = w; height_in = h; start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic press(input logic [3:0] b);
        btn = b; repeat (3) step(); btn = '0; repeat (3) step();
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; btn = '0; width_in = '0; height_in = '0;
        @(negedge clk);
        step(); step();
        chk("rst_path", 32'(path_data), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        reset = 1'b1;

        go(3'd3, 3'd3);
        chk("start_path", 32'(path_data), 32'h001);
        chk("start_busy", 32'(busy), 32'h1);
        press(4'b0100); press(4'b0100); press(4'b0001); press(4'b0001);
        chk("walk_path", 32'(path_data), 32'h127);
        chk("walk_cnt", 32'(move_count), 32'd4);
        chk("walk_done", 32'(done), 32'h1);
        press(4'b0001);
        chk("after_done_cnt", 32'(move_count), 32'd4);
        chk("after_done_x", 32'(cur_x), 32'd2);

        do_reset();
        go(3'd2, 3'd2);
        blk_seen = 0;
        press(4'b0010);
        chk("blk_pulses", 32'(blk_seen), 32'd1);
        chk("blk_x", 32'(cur_x), 32'd0);
        chk("blk_cnt", 32'(move_count), 32'd0);

        go(3'd3, 3'd3);
        press(4'b0100);
        press(4'b1001);
        chk("prio_x", 32'(cur_x), 32'd0);
        chk("prio_y", 32'(cur_y), 32'd0);
        chk("prio_cnt", 32'(move_count), 32'd2);

        do_reset();
        go(3'd4, 3'd2);
        chk("bad_err", 32'(err), 32'h1);
        chk("bad_busy", 32'(busy), 32'h0);
        go(3'd1, 3'd1);
        chk("one_err", 32'(err), 32'h0);
        chk("one_done", 32'(done), 32'h1);
        chk("one_path", 32'(path_data), 32'h001);

        go(3'd3, 3'd3);
        btn = 4'b0100;
        step(); chk("hold_k", 32'(cur_y), 32'd0);
        step(); chk("hold_k1", 32'(cur_y), 32'd0);
        step(); chk("hold_k2", 32'(cur_y), 32'd1);
        repeat (17) step();
        chk("hold_once", 32'(move_count), 32'd1);
        btn = '0; step();
        reset = 1'b0; step(); reset = 1'b1;
        chk("midrst_path", 32'(path_data), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        press(4'b0001);
        chk("midrst_x", 32'(cur_x), 32'd0);
        chk("midrst_cnt", 32'(move_count), 32'd0);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) btn[$urandom_range(0, 3)] ^= 1'b1;
            width_in  = 3'($urandom_range(0, 9) < 8 ? $urandom_range(1, 3) : $urandom_range(0, 7));
            height_in = 3'($urandom_range(0, 9) < 8 ? $urandom_range(1, 3) : $urandom_range(0, 7));
            start = ($urandom_range(0, 39) == 0);
            reset = ($urandom_range(0, 299) != 0);
            step();
        end
        start = 1'b0; reset = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/maze_path_writer.md
Name: maze_path_writer

Overview:
- Produces the 9-bit `path_data` word and maze dimensions consumed by the maze VGA renderer; it is the writer end of the `path_data` interface.
- A player steers a cursor with four push buttons across a grid of up to 3x3 cells. Every visited cell's path bit is set.
- A control FSM handles start, running, completion at the far corner, and rejection of illegal dimensions.

Parameters:
- GRID_MAX, 3, maximum cells per axis; `path_data` holds GRID_MAX*GRID_MAX bits.
- IDX_W, 2, width of the cursor coordinates.
- CNT_W, 8, width of the move counter.

Ports:
- `clk`  input  1  system clock (also drives the renderer).
- `reset`  input  1  synchronous, active-low reset; sampled on the rising edge of `clk`.
- `start`  input  1  single-cycle pulse; begins or restarts a maze.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`  input  1 each  raw, debounced, level button inputs; asynchronous to `clk`.
- `width_in`, `height_in`  input  3 each  requested dimensions, sampled only on `start`.
- `path_data`  output  9  visited map; bit index = 3*x + y (x = column, y = row); 1 = visited.
- `maze_width`, `maze_height`  output  3 each  latched dimensions, driven to the renderer.
- `cur_x`, `cur_y`  output  IDX_W each  cursor position.
- `busy`  output  1  high in RUN.
- `done`  output  1  high in DONE.
- `err`  output  1  sticky; last `start` had illegal dimensions.
- `blocked`  output  1  one-cycle pulse; a move was attempted at the grid boundary.
- `move_count`  output  CNT_W  number of accepted moves.

Behaviour:
- Reset (`reset`=0 at a rising edge):
  - FSM goes to IDLE.
  - All outputs go to 0: `path_data`, `maze_width`, `maze_height`, `cur_x`, `cur_y`, `busy`, `done`, `err`, `blocked`, `move_count`.
  - Synchronizer and edge registers clear to 0.
  - Reset overrides `start` and moves in the same cycle.
  - Reset mid-RUN discards the run.
- Button path:
  - Each button passes through a 2-FF synchronizer followed by a rising-edge detector.
  - A button first sampled high at edge k produces an action registered at edge k+2.
  - Outputs change after edge k+2.
  - A held button yields exactly one move.
- Simultaneous edge pulses: only the highest-priority one is taken, in the order up > down > left > right. Lower-priority pulses in that cycle are discarded.
- Direction meanings:
  - up = `cur_y`-1
  - down = `cur_y`+1
  - left = `cur_x`-1
  - right = `cur_x`+1
- IDLE:
  - Moves are ignored.
  - On `start` with 1 <= `width_in` <= 3 and 1 <= `height_in` <= 3:
    - latch dims into `maze_width`/`maze_height` and clear `err`;
    - set `path_data` = 9'b000000001 (cell 0,0 visited), cursor = (0,0), `move_count` = 0;
    - go to RUN, or directly to DONE if dims are 1x1.
  - On `start` with any dimension 0 or >3: set `err`=1, leave every other register unchanged, stay in IDLE.
- RUN:
  - Accepted move:
    - update the cursor;
    - set `path_data`[3*x'+y'] at the new position; bits are never cleared during a run, and revisiting a cell is legal;
    - increment `move_count`, saturating at 2^CNT_W-1.
  - Move that would leave [0, `maze_width`-1] x [0, `maze_height`-1]:
    - cursor, path and count are unchanged;
    - `blocked`=1 for one cycle.
  - A move landing on (`maze_width`-1, `maze_height`-1) takes effect and the FSM goes to DONE on the same edge.
  - `start` in RUN restarts: same as the IDLE start, re-validating dims. Illegal dims set `err` and return to IDLE with `path_data` retained.
  - `start` and a move in the same cycle: `start` wins and the move is dropped.
- DONE:
  - `done`=1 and `busy`=0.
  - Moves are ignored and `blocked` stays 0.
  - All outputs hold.
  - `start` behaves as in IDLE.
- Dimension inputs changing outside a `start` cycle have no effect.
- `path_data` bits above 3*(`maze_width`-1)+(`maze_height`-1) stay 0.

Test Plan:
- Reset then `start` with 3x3: `path_data`=0x001, cursor (0,0), `busy`=1, `move_count`=0.
- 3x3 run with moves down, down, right, right:
  - path bits 0, 1, 2, 5, 8 set, giving `path_data`=0x127;
  - `move_count`=4;
  - `done`=1 on the edge the last move is registered;
  - a further right press is ignored.
- 2x2, press left at (0,0): `blocked` pulses for 1 cycle; `cur_x`=0 and `move_count`=0 unchanged.
- Up and right asserted on the same cycle at (0,1) of 3x3: only up is taken; cursor becomes (0,0).
- `start` with `width_in`=4 in IDLE: `err`=1 and the FSM stays in IDLE. A following `start` with 1x1: `err`=0, `done`=1 immediately, `path_data`=0x001.
- Button held 20 cycles gives exactly one move, at edge k+2. Asserting `reset`=0 mid-RUN clears all outputs on that edge; moves are ignored until the next `start`.
